// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART packet transmitter and its receiver twin.
//   - calc_bps_cnt : clock cycles per bit (integer-truncated divide)
//   - crc8_update  : byte-wise CRC8 step, polynomial 0x07, MSB first
//   - CRC8_POLY, HEAD_DEFAULT constants
//   - ST_* state encodings, kept identical on both sides of the link
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [7:0] CRC8_POLY    = 8'h07;
  localparam logic [7:0] HEAD_DEFAULT = 8'h5A;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP,
    S_NEXT  = ST_NEXT
  } uart_state_e;

  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // One byte through the CRC8 register, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data_in);
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Single-byte 8N1 serialiser, LSB first; owns the baud and bit counters.
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   synchronous active-high reset
//   byte_start in   load byte_data and begin the start bit on this edge
//   byte_data  in   8-bit character to send
//   byte_done  out  high in the final cycle of the stop bit; a byte_start in
//                   that cycle chains the next character with no gap
//   txd        out  registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int BPS_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       txd
);

  localparam int               CNT_W     = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_CNT - 1);

  uart_state_e      r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_txd;
  logic             w_bit_end;

  assign w_bit_end = (r_baud_cnt == BAUD_LAST);
  // Combinational so the parent can restart in the same edge the stop bit ends.
  assign byte_done = (r_state == S_STOP) && w_bit_end;
  assign txd       = r_txd;

  // Bit-level state machine: start bit, eight data bits, stop bit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= CNT_W'(0);
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_txd      <= 1'b1;
    end else if (byte_start) begin
      r_state    <= S_START;
      r_baud_cnt <= CNT_W'(0);
      r_bit_cnt  <= 3'd0;
      r_shift    <= byte_data;
      r_txd      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= CNT_W'(0);
          r_txd      <= 1'b1;
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= CNT_W'(0);
            r_state    <= S_DATA;
            r_txd      <= r_shift[0];
            r_shift    <= {1'b0, r_shift[7:1]};
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= CNT_W'(0);
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= 3'd0;
              r_state   <= S_STOP;
              r_txd     <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= CNT_W'(0);
            r_state    <= S_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= CNT_W'(0);
          r_txd      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_mult_byte_tx
// Multi-byte UART packet transmitter: header, PACK_LEN payload bytes (byte 0
// first) and, when macro UART_TX_CRC8_EN is defined, a CRC8 over the payload.
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   synchronous active-high reset
//   send_start in   one-cycle request, honoured only while idle
//   tx_pack    in   payload, byte k at [8k+7:8k]
//   busy       out  frame in progress
//   send_done  out  one-cycle pulse after the last stop bit
//   byte_idx   out  index of the byte on the line (0 = header)
//   uart_txd   out  serial line, idles high
// Optional feature: UART_TX_CRC8_EN appends the CRC8 byte.
// -----------------------------------------------------------------------------
module uart_mult_byte_tx
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         UART_BPS  = 115200,
  parameter int         PACK_LEN  = 11,
  parameter logic [7:0] HEAD_BYTE = HEAD_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  send_start,
  input  logic [PACK_LEN*8-1:0] tx_pack,
  output logic                  busy,
  output logic                  send_done,
  output logic [7:0]            byte_idx,
  output logic                  uart_txd
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
`ifdef UART_TX_CRC8_EN
  localparam int N_CRC = 1;
`else
  localparam int N_CRC = 0;
`endif
  // Nine bits so PACK_LEN=255 plus CRC still reaches its last index.
  localparam logic [8:0] LAST_IDX = 9'(PACK_LEN + N_CRC);
  localparam logic [8:0] PAY_END  = 9'(PACK_LEN);

  logic                  r_busy;
  logic                  r_send_done;
  logic [8:0]            r_byte_idx;
  logic [PACK_LEN*8-1:0] r_pack;
`ifdef UART_TX_CRC8_EN
  logic [7:0]            r_crc;
`endif

  logic       w_byte_done;
  logic       w_byte_start;
  logic [7:0] w_byte_data;
  logic       w_last;
  logic       w_next_payload;

  assign w_last         = (r_byte_idx == LAST_IDX);
  assign w_next_payload = (r_byte_idx < PAY_END);
  // The zero-length NEXT step: chain the next byte on the stop-bit end edge.
  assign w_byte_start   = (!r_busy && send_start) ||
                          (r_busy && w_byte_done && !w_last);

  assign busy      = r_busy;
  assign send_done = r_send_done;
  assign byte_idx  = r_byte_idx[7:0];

  // Select the character handed to the serialiser on the next byte_start.
  always_comb begin
    w_byte_data = HEAD_BYTE;
    if (!r_busy) begin
      w_byte_data = HEAD_BYTE;
    end else if (w_next_payload) begin
      // The latch is consumed as a shift register, so the next byte is at [7:0].
      w_byte_data = r_pack[7:0];
    end else begin
`ifdef UART_TX_CRC8_EN
      w_byte_data = r_crc;
`else
      w_byte_data = 8'h00;
`endif
    end
  end

  // Packet sequencing, payload latch and running CRC.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_busy      <= 1'b0;
      r_send_done <= 1'b0;
      r_byte_idx  <= 9'd0;
      r_pack      <= {(PACK_LEN*8){1'b0}};
`ifdef UART_TX_CRC8_EN
      r_crc       <= 8'h00;
`endif
    end else begin
      r_send_done <= 1'b0;
      if (!r_busy) begin
        if (send_start) begin
          r_busy     <= 1'b1;
          r_byte_idx <= 9'd0;
          r_pack     <= tx_pack;
`ifdef UART_TX_CRC8_EN
          r_crc      <= 8'h00;
`endif
        end else begin
          r_byte_idx <= 9'd0;
        end
      end else if (w_byte_done) begin
        if (w_last) begin
          r_busy      <= 1'b0;
          r_send_done <= 1'b1;
          r_byte_idx  <= 9'd0;
        end else begin
          r_byte_idx <= r_byte_idx + 9'd1;
          if (w_next_payload) begin
            r_pack <= r_pack >> 8;
`ifdef UART_TX_CRC8_EN
            r_crc  <= crc8_update(r_crc, r_pack[7:0]);
`endif
          end
        end
      end
    end
  end

  uart_byte_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_byte_tx (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .byte_start (w_byte_start),
    .byte_data  (w_byte_data),
    .byte_done  (w_byte_done),
    .txd        (uart_txd)
  );

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_mult_byte_tx
// Directed bench for uart_mult_byte_tx at BPS_CNT = 10, PACK_LEN = 2.
// Expected line bytes are queued when a frame is started and popped as each
// character is reassembled from the line; every cycle of every bit is checked.
// -----------------------------------------------------------------------------
module tb_uart_mult_byte_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BPS      = 10;
  localparam int PACK_LEN = 2;
  localparam int PW       = PACK_LEN * 8;
`ifdef UART_TX_CRC8_EN
  localparam int NCRC = 1;
`else
  localparam int NCRC = 0;
`endif
  localparam int NBYTES    = 1 + PACK_LEN + NCRC;
  localparam int FRAME_CYC = NBYTES * 10 * BPS;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          send_start;
  logic [PW-1:0] tx_pack;
  logic          busy;
  logic          send_done;
  logic [7:0]    byte_idx;
  logic          uart_txd;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_mult_byte_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .PACK_LEN  (PACK_LEN),
    .HEAD_BYTE (8'h5A)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .send_start (send_start),
    .tx_pack    (tx_pack),
    .busy       (busy),
    .send_done  (send_done),
    .byte_idx   (byte_idx),
    .uart_txd   (uart_txd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef UART_TX_CRC8_EN
  // Bit-serial CRC8 (poly 0x07, init 0) over the payload bytes in send order.
  function automatic logic [7:0] ref_crc(input logic [PW-1:0] p);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int k = 0; k < PACK_LEN; k++) begin
      for (int b = 7; b >= 0; b--) begin
        fb  = crc[7] ^ p[8*k+b];
        crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return crc;
  endfunction
`endif

  // Called at a negedge; the request is sampled by the following posedge.
  task automatic do_start(input logic [PW-1:0] p);
    send_start = 1'b1;
    tx_pack    = p;
    sb.push_back(8'h5A);
    for (int k = 0; k < PACK_LEN; k++) sb.push_back(p[8*k +: 8]);
`ifdef UART_TX_CRC8_EN
    sb.push_back(ref_crc(p));
`endif
    @(negedge clk);
    send_start = 1'b0;
  endtask

  // Entered at the negedge just after acceptance (cycle 0 of the frame).
  task automatic watch_frame(input int inject_at, input int rst_at, input logic [PW-1:0] inj);
    logic [9:0] obs;
    logic       glitch;
    logic [7:0] exp;
    int         b, i, j;
    obs    = 10'd0;
    glitch = 1'b0;
    for (int n = 0; n < FRAME_CYC; n++) begin
      b = n / (10 * BPS);
      i = (n / BPS) % 10;
      j = n % BPS;
      if (j == 0) begin
        obs[i] = uart_txd;
        if (i == 0) begin
          glitch = 1'b0;
          chk("byte_idx", {24'd0, byte_idx}, b);
          chk("busy_mid", {31'd0, busy}, 1);
          chk("done_mid", {31'd0, send_done}, 0);
        end
      end else if (uart_txd !== obs[i]) begin
        glitch = 1'b1;
      end
      if (i == 9 && j == BPS - 1) begin
        chk("sb_nonempty", {31'd0, sb.size() > 0}, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("frame_bits", {22'd0, obs}, {22'd0, 1'b1, exp, 1'b0});
        chk("bit_width", {31'd0, glitch}, 0);
      end
      if (n == inject_at) begin
        send_start = 1'b1;
        tx_pack    = inj;
      end else if (n == inject_at + 1) begin
        send_start = 1'b0;
      end
      if (n == rst_at) sys_rst = 1'b1;
      @(negedge clk);
      if (n == rst_at) begin
        sys_rst = 1'b0;
        chk("rst_txd", {31'd0, uart_txd}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_idx", {24'd0, byte_idx}, 0);
        chk("rst_done", {31'd0, send_done}, 0);
        sb.delete();
        return;
      end
    end
    chk("done_pulse", {31'd0, send_done}, 1);
    chk("busy_end", {31'd0, busy}, 0);
    chk("txd_end", {31'd0, uart_txd}, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic idle_watch(input int cycles);
    int bad_txd, bad_busy, bad_done;
    bad_txd  = 0;
    bad_busy = 0;
    bad_done = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) bad_txd++;
      if (busy !== 1'b0) bad_busy++;
      if (send_done !== 1'b0) bad_done++;
    end
    chk("idle_txd", bad_txd, 0);
    chk("idle_busy", bad_busy, 0);
    chk("idle_done", bad_done, 0);
  endtask

  initial begin
    logic [PW-1:0] rnd;
    sys_rst    = 1'b1;
    send_start = 1'b0;
    tx_pack    = '0;
    repeat (2) @(negedge clk);
    chk("reset_txd", {31'd0, uart_txd}, 1);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, send_done}, 0);
    chk("reset_idx", {24'd0, byte_idx}, 0);
    sys_rst = 1'b0;

    // Idle line after reset.
    idle_watch(1000);

    // Single frame, then a back-to-back start in the send_done cycle.
    do_start(16'hA55A);
    watch_frame(-1, -1, '0);
    do_start(16'h1234);
    watch_frame(-1, -1, '0);
    idle_watch(20);

    // Start request with new payload while busy must be ignored.
    do_start(16'hC33C);
    watch_frame(50, -1, 16'hFFFF);
    idle_watch(300);

    // Reset mid-frame, then a clean frame.
    do_start(16'h0F0F);
    watch_frame(-1, 137, '0);
    idle_watch(400);
    do_start(16'h9E37);
    watch_frame(-1, -1, '0);
    idle_watch(10);

    for (int r = 0; r < 2; r++) begin
      rnd = PW'($urandom());
      do_start(rnd);
      watch_frame(-1, -1, '0);
      idle_watch(5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mult_byte_tx.md
# uart_mult_byte_tx

Multi-byte UART packet transmitter, the transmit counterpart of the multi-byte UART packet receiver. It sits in the 50 MHz domain of the DDS sample top. On a start pulse it captures a flat payload bus and serialises a frame onto `uart_txd`: one header byte, `PACK_LEN` payload bytes and, optionally, a CRC8 byte. Each byte is sent as 8N1, LSB first.

## Interface

Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `UART_BPS`, 115200: baud rate.
- `PACK_LEN`, 11: number of payload bytes, range 1..255.
- `HEAD_BYTE`, 8'h5A: frame header byte.

Ports:
- `sys_clk`  input  1: system clock (clk_50M in the top).
- `sys_rst`  input  1: synchronous, active-high reset.
- `send_start`  input  1: single-cycle request to send a packet.
- `tx_pack`  input  PACK_LEN*8: payload; byte k sits in `[8k+7:8k]`, and byte 0 is sent first.
- `busy`  output  1: high while a frame is in progress.
- `send_done`  output  1: single-cycle pulse when the frame completes.
- `byte_idx`  output  8: index of the byte currently on the line (0 = header).
- `uart_txd`  output  1: serial line, idles high.

## Operation

- `BPS_CNT = CLK_FREQ / UART_BPS`, using integer truncation; the default is 434.
- States:
  - IDLE
  - START (start bit, 0)
  - DATA (bits 0..7, LSB first)
  - STOP (stop bit, 1)
  - NEXT (selects the next byte or finishes)
- Acceptance:
  - `send_start` is accepted only in IDLE.
  - On acceptance, `tx_pack` is latched into an internal register and the block enters START with header byte selected.
  - `send_start` while `busy` is ignored; it is neither queued nor allowed to corrupt the latch.
  - Changes on `tx_pack` after acceptance have no effect on the frame in progress.
- Bit timing: each bit is held for exactly `BPS_CNT` cycles, counted by a baud counter that reloads on every bit boundary.
- Byte sequence: header, payload 0 .. `PACK_LEN-1`, then CRC if it is compiled in.
  - `byte_idx` runs from 0 to `PACK_LEN`, or to `PACK_LEN+1` with CRC.
- NEXT lasts 0 cycles: the START of the next byte begins directly after STOP ends, so there is no inter-byte gap.
- After the last STOP, the block returns to IDLE, pulses `send_done` for one cycle and drops `busy` in that same cycle.
- A `send_start` in the `send_done` cycle is accepted, giving back-to-back frames.
- Reset:
  - Asserting `sys_rst` at any point, including mid-byte, returns the block to IDLE within one cycle.
  - Reset values: `uart_txd`=1, `busy`=0, `send_done`=0, `byte_idx`=0; baud counter, bit counter and CRC are all 0.
  - A truncated character on the line is acceptable.

## Timing

- `uart_txd` falls and `busy` rises in the first cycle after the `send_start` sample edge, so latency is 1 cycle.
- Frame length is `(1 + PACK_LEN + C) * 10 * BPS_CNT` cycles, where C = 1 with CRC and 0 without.
- `send_done` asserts the cycle after the last stop-bit period completes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- Macro `UART_TX_CRC8_EN`.
- When defined:
  - A CRC8 byte is appended after the payload.
  - Polynomial is 0x07, initial value 0x00, no reflection, no final XOR.
  - The CRC covers payload bytes only, not the header.
  - It is computed byte-wise as each payload byte is loaded, so it is ready before the CRC byte starts.
- When undefined: no CRC logic exists, the frame ends after payload byte `PACK_LEN-1`, and `byte_idx` peaks at `PACK_LEN`.

## Structure

- Package `uart_pkg` holds:
  - the `BPS_CNT` computation function;
  - the CRC8 polynomial constant (8'h07);
  - the default header constant;
  - state encoding localparams, shared with the receiver for parity checks.
- Sub-module `uart_byte_tx` is the natural split. It is a single-byte 8N1 serialiser with ports `byte_start`, `byte_data`, `byte_done` and `txd`, and it owns the baud and bit counters.
- The top level owns the packet sequencing, the payload latch and the CRC.

## Test plan

All scenarios use `CLK_FREQ`=1_000_000 and `UART_BPS`=100_000, giving `BPS_CNT`=10.

- **Single frame:** PACK_LEN=2, tx_pack=16'hA55A, no CRC, one start pulse. Line carries 5A, 5A, A5. `send_done` comes 300 cycles after start, and each bit is exactly 10 cycles.
- **CRC check value:** with `UART_TX_CRC8_EN`, PACK_LEN=9, payload ASCII "123456789". The byte after the payload is 0xF4, and the frame is 1100 cycles.
- **Busy-ignore:** start pulse, then a second `send_start` with a new `tx_pack` at cycle 50. Only one frame is sent, it carries the original payload, and there is no second `send_done`.
- **Back-to-back:** `send_start` in the `send_done` cycle. The next start bit follows with `uart_txd` staying high for 0 extra cycles, and `busy` is high again the next cycle.
- **Reset mid-frame:** `sys_rst` asserted for 1 cycle at cycle 137. The next cycle shows `uart_txd`=1, `busy`=0, `byte_idx`=0, and no `send_done`. A new start afterwards produces a complete, correct frame.
- **Idle:** no start for 1000 cycles after reset. `uart_txd` stays 1 and `busy` stays 0 throughout.
